// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// slave modport: arbiter side; master modport: requester/memory side.
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_err;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic [ADDR_W-1:0] mem_a;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rd,
        output p0_ack, p0_err, p1_ack, p1_err,
        output rdata, busy,
        output mem_a, mem_we, mem_wd
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rd,
        input  p0_ack, p0_err, p1_ack, p1_err,
        input  rdata, busy,
        input  mem_a, mem_we, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (P0 = LSU, P1 = loader/debug).
// IDLE picks a winner and registers its command; ACCESS drives the memory for one cycle and
// returns ack/err/rdata on the following cycle.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin on ties; default is fixed
// priority with P0 winning.
module dmem_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = 2048
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    dmem_arbiter_if.slave  io_bus
);
    // One past the last valid byte address; one extra bit so the compare cannot wrap.
    localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(64'(MEM_WORDS) * 64'd4);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e            r_state;
    logic              r_cmd_we;
    logic              r_cmd_id;
    logic              r_cmd_err;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_p0_ack;
    logic              r_p0_err;
    logic              r_p1_ack;
    logic              r_p1_err;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant_id;
    logic              w_grant_we;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_grant_wdata;
    logic              w_grant_err;

    // A port whose ack is high this cycle has just completed and is not re-granted yet.
    assign w_elig0 = io_bus.p0_req & ~r_p0_ack;
    assign w_elig1 = io_bus.p1_req & ~r_p1_ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_id;

    // On a tie, grant the port that was not granted last.
    assign w_grant_id = (w_elig0 & w_elig1) ? ~r_last_id : w_elig1;
`else
    // Fixed priority: P1 only wins when P0 is not eligible.
    assign w_grant_id = ~w_elig0;
`endif

    assign w_grant_we    = w_grant_id ? io_bus.p1_we    : io_bus.p0_we;
    assign w_grant_addr  = w_grant_id ? io_bus.p1_addr  : io_bus.p0_addr;
    assign w_grant_wdata = w_grant_id ? io_bus.p1_wdata : io_bus.p0_wdata;
    assign w_grant_err   = (w_grant_addr[1:0] != 2'b00) | ({1'b0, w_grant_addr} >= AddrLimit);

    // Arbitration FSM with registered command, ack/err pulses and read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cmd_we    <= 1'b0;
            r_cmd_id    <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_rdata     <= '0;
            r_p0_ack    <= 1'b0;
            r_p0_err    <= 1'b0;
            r_p1_ack    <= 1'b0;
            r_p1_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_id   <= 1'b1;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    r_p0_ack <= 1'b0;
                    r_p0_err <= 1'b0;
                    r_p1_ack <= 1'b0;
                    r_p1_err <= 1'b0;
                    if (w_elig0 | w_elig1) begin
                        r_cmd_id    <= w_grant_id;
                        r_cmd_we    <= w_grant_we;
                        r_cmd_addr  <= w_grant_addr;
                        r_cmd_wdata <= w_grant_wdata;
                        r_cmd_err   <= w_grant_err;
                        r_state     <= StAccess;
                    end
                end
                StAccess: begin
                    r_rdata  <= (r_cmd_we | r_cmd_err) ? '0 : io_bus.mem_rd;
                    r_p0_ack <= ~r_cmd_id;
                    r_p0_err <= ~r_cmd_id & r_cmd_err;
                    r_p1_ack <= r_cmd_id;
                    r_p1_err <= r_cmd_id & r_cmd_err;
                    r_state  <= StIdle;
`ifdef ARB_ROUND_ROBIN_EN
                    r_last_id <= r_cmd_id;
`endif
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Memory strobe is combinational from state so an async reset kills it at once.
    assign io_bus.busy   = (r_state == StAccess);
    assign io_bus.mem_we = io_bus.busy & r_cmd_we & ~r_cmd_err;
    assign io_bus.mem_a  = r_cmd_addr;
    assign io_bus.mem_wd = r_cmd_wdata;
    assign io_bus.rdata  = r_rdata;
    assign io_bus.p0_ack = r_p0_ack;
    assign io_bus.p0_err = r_p0_err;
    assign io_bus.p1_ack = r_p1_ack;
    assign io_bus.p1_err = r_p1_err;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: environment memory, transaction-level reference model with a
// per-cycle compare process, directed scenarios with literal expectations, random traffic.
module tb_dmem_arbiter;
    localparam int unsigned MemWords = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .MEM_WORDS (MemWords)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    // Environment memory: comb read, posedge write.
    logic [31:0] mem [MemWords];
    int mwe_cnt = 0;
    assign bus.mem_rd = (bus.mem_a < 32'(MemWords * 4)) ? mem[bus.mem_a[12:2]] : 32'h0;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mwe_cnt <= mwe_cnt + 1;
            if (bus.mem_a < 32'(MemWords * 4)) mem[bus.mem_a[12:2]] <= bus.mem_wd;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction with the cycles it is accessed and acked.
    logic [31:0] ref_mem [MemWords];
    longint      cyc     = 0;
    longint      acc_cyc = -10;
    longint      ack_cyc = -10;
    logic        m_id    = 1'b0;
    logic        m_we    = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rd    = '0;
    logic [31:0] m_rdata = '0;
    logic        m_last  = 1'b1;

    always @(negedge clk) begin
        logic        acc, ackc, e0, e1, w;
        logic [31:0] a;
        if (!rst_n) begin
            check("rst_p0_ack", bus.p0_ack, 0);
            check("rst_p1_ack", bus.p1_ack, 0);
            check("rst_p0_err", bus.p0_err, 0);
            check("rst_p1_err", bus.p1_err, 0);
            check("rst_rdata",  bus.rdata,  0);
            check("rst_busy",   bus.busy,   0);
            check("rst_mem_a",  bus.mem_a,  0);
            check("rst_mem_wd", bus.mem_wd, 0);
            check("rst_mem_we", bus.mem_we, 0);
            acc_cyc = -10;
            ack_cyc = -10;
            m_id = 0; m_we = 0; m_err = 0; m_addr = 0; m_wdata = 0; m_rd = 0; m_rdata = 0;
            m_last = 1'b1;
        end else begin
            acc  = (cyc == acc_cyc);
            ackc = (cyc == ack_cyc);
            if (ackc) begin
                m_rdata = m_rd;
                if (m_we && !m_err) ref_mem[m_addr[12:2]] = m_wdata;
            end
            check("busy",   bus.busy,   acc);
            check("mem_we", bus.mem_we, acc && m_we && !m_err);
            check("mem_a",  bus.mem_a,  m_addr);
            check("mem_wd", bus.mem_wd, m_wdata);
            check("p0_ack", bus.p0_ack, ackc && m_id == 0);
            check("p1_ack", bus.p1_ack, ackc && m_id == 1);
            check("p0_err", bus.p0_err, ackc && m_id == 0 && m_err);
            check("p1_err", bus.p1_err, ackc && m_id == 1 && m_err);
            check("rdata",  bus.rdata,  m_rdata);
            if (!acc) begin
                e0 = bus.p0_req && !(ackc && m_id == 0);
                e1 = bus.p1_req && !(ackc && m_id == 1);
                if (e0 || e1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (e0 && e1) w = (m_last == 1'b0) ? 1'b1 : 1'b0;
                    else          w = e1;
`else
                    w = e0 ? 1'b0 : 1'b1;
`endif
                    m_last  = w;
                    m_id    = w;
                    m_we    = w ? bus.p1_we    : bus.p0_we;
                    m_addr  = w ? bus.p1_addr  : bus.p0_addr;
                    m_wdata = w ? bus.p1_wdata : bus.p0_wdata;
                    a       = m_addr;
                    m_err   = (a % 4 != 0) || (a >= 32'(MemWords * 4));
                    m_rd    = (m_we || m_err) ? 32'h0 : ref_mem[a / 4];
                    acc_cyc = cyc + 1;
                    ack_cyc = cyc + 2;
                end
            end
        end
        cyc++;
    end

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    function automatic logic get_ack(input int p);
        return (p == 0) ? bus.p0_ack : bus.p1_ack;
    endfunction

    function automatic logic get_req(input int p);
        return (p == 0) ? bus.p0_req : bus.p1_req;
    endfunction

    // One blocking transaction; lat counts clock edges from request to ack.
    task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic err, output logic [31:0] rd);
        @(posedge clk); #1;
        set_port(p, 1'b1, we, a, d);
        lat = 0;
        err = 1'b0;
        rd  = 32'h0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (get_ack(p)) break;
        end
        if (!get_ack(p)) check("txn_timeout", 0, 1);
        err = (p == 0) ? bus.p0_err : bus.p1_err;
        rd  = bus.rdata;
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        case (r)
            0:       return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            1:       return 32'h2000 + 32'($urandom_range(0, 15) * 4);
            2:       return 32'h1FFC;
            3:       return $urandom() & 32'hFFFF_FFFC;
            default: return 32'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    initial begin
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic [31:0] w1_before;
        int          mwe_before;
        int          order[$];
        longint      ack_at[$];

        for (int i = 0; i < int'(MemWords); i++) begin
            mem[i]     = {16'hC0DE, 16'(i)};
            ref_mem[i] = {16'hC0DE, 16'(i)};
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // T1: write then read back.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, err, rd);
        check("t1_wr_lat", lat, 2);
        check("t1_wr_err", err, 0);
        txn(0, 1'b0, 32'h10, 32'h0, lat, err, rd);
        check("t1_rd_lat", lat, 2);
        check("t1_rd_err", err, 0);
        check("t1_rdata", rd, 32'hDEADBEEF);

        // T3: misaligned write from P1 is rejected and never strobes memory.
        w1_before  = mem[1];
        mwe_before = mwe_cnt;
        txn(1, 1'b1, 32'h6, 32'hCAFE_F00D, lat, err, rd);
        check("t3_lat", lat, 2);
        check("t3_err", err, 1);
        check("t3_rdata", rd, 0);
        @(posedge clk); #1;
        check("t3_word4", mem[1], w1_before);
        check("t3_no_we", mwe_cnt - mwe_before, 0);

        // T4: out-of-range read and the last valid word.
        txn(0, 1'b0, 32'h2000, 32'h0, lat, err, rd);
        check("t4_err", err, 1);
        check("t4_rdata", rd, 0);
        txn(0, 1'b0, 32'h1FFC, 32'h0, lat, err, rd);
        check("t4_last_err", err, 0);
        check("t4_last_rdata", rd, 32'hC0DE07FF);

        // T5: reset in the middle of a write.
        txn(0, 1'b1, 32'h20, 32'h5555AAAA, lat, err, rd);
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 32'h20, 32'h1234);
        @(posedge clk); #1;
        check("t5_busy", bus.busy, 1);
        check("t5_we", bus.mem_we, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_we_drop", bus.mem_we, 0);
        check("t5_busy_drop", bus.busy, 0);
        check("t5_no_ack", bus.p0_ack, 0);
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        txn(0, 1'b0, 32'h20, 32'h0, lat, err, rd);
        check("t5_rdata", rd, 32'h5555AAAA);

        // T2: both ports read continuously; the no-regrant rule makes grants alternate.
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h14, 32'h0);
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.p0_ack) order.push_back(0);
            if (bus.p1_ack) order.push_back(1);
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t2_count", order.size() >= 4, 1);
        if (order.size() >= 4) begin
            check("t2_g0", order[0], 0);
            check("t2_g1", order[1], 1);
            check("t2_g2", order[2], 0);
            check("t2_g3", order[3], 1);
        end

        // T6: single port holding req sees one grant every 3 cycles.
        repeat (3) @(posedge clk);
        #1 set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.p0_ack) ack_at.push_back(longint'(i));
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t6_count", ack_at.size() >= 3, 1);
        if (ack_at.size() >= 3) begin
            check("t6_period_a", 32'(ack_at[1] - ack_at[0]), 3);
            check("t6_period_b", 32'(ack_at[2] - ack_at[1]), 3);
        end

        // Random traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (get_req(p)) begin
                    if (get_ack(p)) begin
                        if ($urandom_range(0, 1) == 0)
                            set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
                        else
                            set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
                end
            end
        end
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
